xpt_step_sequencer: RTL and testbench
=====================================

Name: xpt_step_sequencer

Overview:
- Generates the one-hot execution timing step XPT[4:0], its complement notXPT[4:0], and the XOTR-group enable that drive the XOTR op decoders (e.g. NEG).
- Sits directly upstream of those decoders and consumes their control strobes (PR_Reset_XPT, P2_Reset_XOTR, P2_Set_CM1) to close the loop.
- Also owns the CM1 (start-new-M1 request) flag that the fetch controller samples.

Parameters:
- XPT_W, 5, number of timing steps; one-hot width of XPT/notXPT.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on rising clk.
- step_en  in  1  advance request for the current step (core running).
- wait_n  in  1  memory/bus wait, active-low; 0 freezes XPT.
- set_xotr  in  1  XOTR-group opcode fetched; arms the group.
- PR_Reset_XPT  in  1  from decoders: return to step 0.
- P2_Reset_XOTR  in  1  from decoders: leave XOTR group.
- P2_Set_CM1  in  1  from decoders: request new M1.
- m1_ack  in  1  fetch controller accepted CM1.
- XPT  out  XPT_W  one-hot current step, registered.
- notXPT  out  XPT_W  bitwise complement of XPT, own register bank.
- xotr_enable  out  1  XOTR decoder enable.
- CM1  out  1  pending M1 request.
- xpt_error  out  1  sticky overrun flag; only with the optional feature, else tied 0.

Behaviour:
- Reset (rst_n=0 at edge): XPT=00001, notXPT=11110, xotr_enable=0, CM1=0, xpt_error=0. Reset overrides every other input.
- Advance condition adv = step_en & wait_n.
- XPT next-state priority, highest first:
  1. rst_n low → reset values.
  2. PR_Reset_XPT → 00001. Taken even when wait_n=0.
  3. XPT not one-hot (illegal) → 00001.
  4. adv → rotate left one position; XPT[4] wraps to 00001.
  5. Otherwise hold.
- notXPT is computed from the same next-state value and registered in parallel, so XPT ^ notXPT == all-ones every cycle. Never derive it combinationally from the XPT outputs.
- Latency: a strobe sampled at edge N is reflected at outputs after edge N; XPT changes at most one step per cycle.
- xotr_enable:
  - Set by set_xotr; cleared by P2_Reset_XOTR.
  - Simultaneous set and clear → clear wins (0).
  - Unaffected by wait_n.
- CM1:
  - Set by P2_Set_CM1; cleared by m1_ack.
  - Simultaneous set and ack → set wins (1); the new request is not lost.
- Decoder strobes are single-cycle and combinational from XPT. The sequencer must not depend on them being held.
- A decoder step that asserts PR_Reset_XPT together with P2_Reset_XOTR and P2_Set_CM1 (final step of NEG) yields, next cycle: XPT=00001, xotr_enable=0, CM1=1.

Optional Feature:
- Macro XPT_OVERRUN_TRAP_EN.
- Defined:
  - adv at XPT[4] without PR_Reset_XPT sets xpt_error (sticky until reset).
  - XPT holds at 10000 instead of wrapping.
  - An illegal non-one-hot state also sets xpt_error.
- Undefined: wrap to 00001 silently; xpt_error tied 0.

Decomposition:
- Shared package norz_timing_pkg holds:
  - XPT_W;
  - typedef xpt_t (logic [XPT_W-1:0]);
  - constants XPT_STEP0=00001 and XPT_LAST=10000.
- One sub-module: xpt_onehot_ring. It contains the XPT/notXPT register pair, the rotate logic and the one-hot check. Flags stay in the top level.

Test Plan:
- Reset, then step_en=1, wait_n=1 for 5 cycles → XPT sequence 00010, 00100, 01000, 10000, 00001; notXPT is the complement each cycle.
- At XPT=00100, wait_n=0 for 3 cycles → XPT holds 00100. Then PR_Reset_XPT pulse with wait_n still 0 → XPT=00001 next cycle.
- set_xotr at cycle 2; at XPT=01000 assert PR_Reset_XPT + P2_Reset_XOTR + P2_Set_CM1 together → next cycle XPT=00001, xotr_enable=0, CM1=1. m1_ack → CM1=0.
- set_xotr and P2_Reset_XOTR in the same cycle → xotr_enable=0. P2_Set_CM1 and m1_ack in the same cycle → CM1=1.
- rst_n=0 mid-run at XPT=01000, xotr_enable=1, CM1=1 → after the edge all outputs are at reset values, regardless of step_en or strobes.
- With XPT_OVERRUN_TRAP_EN: advance at 10000 with no PR_Reset_XPT → XPT stays 10000 and xpt_error=1 until rst_n. Without the macro → XPT=00001 and xpt_error=0.

Source files
------------

// File: rtl/norz_timing_pkg.sv
// Shared timing-step definitions for the XPT sequencer and the XOTR decoders.
package norz_timing_pkg;

   localparam int unsigned XPT_W = 5;

   typedef logic [XPT_W-1:0] xpt_t;

   localparam xpt_t XPT_STEP0 = 5'b00001;
   localparam xpt_t XPT_LAST  = 5'b10000;

   // True when exactly one bit of the step vector is set.
   function automatic logic is_onehot(xpt_t v);
      int unsigned cnt;
      cnt = 0;
      for (int i = 0; i < XPT_W; i++) begin
         cnt = cnt + {31'b0, v[i]};
      end
      return (cnt == 1);
   endfunction

endpackage

// File: rtl/xpt_onehot_ring.sv
// One-hot XPT step ring with a parallel complement register bank.
// With XPT_OVERRUN_TRAP_EN defined the ring parks at the last step instead of
// wrapping and reports overruns / illegal states on fault.
module xpt_onehot_ring
   import norz_timing_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic adv,
   input  logic pr_reset,
   output xpt_t xpt,
   output xpt_t not_xpt,
   output logic fault
);

   xpt_t xpt_d, xpt_q;
   xpt_t not_xpt_d, not_xpt_q;
   logic illegal;
   logic at_last;

   assign illegal = ~is_onehot(xpt_q);
   assign at_last = (xpt_q == XPT_LAST);

   // Next step: explicit return, illegal recovery, advance, else hold.
   always_comb begin
      xpt_d = xpt_q;
      if (pr_reset) begin
         xpt_d = XPT_STEP0;
      end else if (illegal) begin
         xpt_d = XPT_STEP0;
      end else if (adv) begin
         if (at_last) begin
`ifdef XPT_OVERRUN_TRAP_EN
            xpt_d = XPT_LAST;
`else
            xpt_d = XPT_STEP0;
`endif
         end else begin
            xpt_d = {xpt_q[XPT_W-2:0], 1'b0};
         end
      end
      // Complement comes from the same next value so both banks agree every cycle.
      not_xpt_d = ~xpt_d;
   end

   // Overrun / illegal-state detection; constant zero when the trap is disabled.
   always_comb begin
      fault = 1'b0;
`ifdef XPT_OVERRUN_TRAP_EN
      fault = illegal | (adv & at_last & ~pr_reset);
`endif
   end

   // Step register pair with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         xpt_q     <= XPT_STEP0;
         not_xpt_q <= ~XPT_STEP0;
      end else begin
         xpt_q     <= xpt_d;
         not_xpt_q <= not_xpt_d;
      end
   end

   assign xpt     = xpt_q;
   assign not_xpt = not_xpt_q;

endmodule

// File: rtl/xpt_step_sequencer.sv
// XOTR execution step sequencer: one-hot XPT ring plus XOTR-enable and CM1 flags.
// Optional macro XPT_OVERRUN_TRAP_EN: park at the last step and raise sticky xpt_error.
module xpt_step_sequencer
   import norz_timing_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             step_en,
   input  logic             wait_n,
   input  logic             set_xotr,
   input  logic             PR_Reset_XPT,
   input  logic             P2_Reset_XOTR,
   input  logic             P2_Set_CM1,
   input  logic             m1_ack,
   output logic [XPT_W-1:0] XPT,
   output logic [XPT_W-1:0] notXPT,
   output logic             xotr_enable,
   output logic             CM1,
   output logic             xpt_error
);

   logic adv;
   logic fault;
   logic xotr_d, xotr_q;
   logic cm1_d, cm1_q;
   logic err_d, err_q;

   // PR_Reset_XPT is deliberately not gated by wait_n.
   assign adv = step_en & wait_n;

   xpt_onehot_ring u_ring (
      .clk      (clk),
      .rst_n    (rst_n),
      .adv      (adv),
      .pr_reset (PR_Reset_XPT),
      .xpt      (XPT),
      .not_xpt  (notXPT),
      .fault    (fault)
   );

   // Flag next-state: clear beats set for XOTR, set beats ack for CM1.
   always_comb begin
      xotr_d = xotr_q;
      if (set_xotr)      xotr_d = 1'b1;
      if (P2_Reset_XOTR) xotr_d = 1'b0;

      cm1_d = cm1_q;
      if (m1_ack)     cm1_d = 1'b0;
      if (P2_Set_CM1) cm1_d = 1'b1;

      err_d = err_q | fault;
   end

   // Flag registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         xotr_q <= 1'b0;
         cm1_q  <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         xotr_q <= xotr_d;
         cm1_q  <= cm1_d;
         err_q  <= err_d;
      end
   end

   assign xotr_enable = xotr_q;
   assign CM1         = cm1_q;
   assign xpt_error   = err_q;

endmodule

// File: tb/tb_xpt_step_sequencer.sv
// Bench for xpt_step_sequencer: directed vector table, then random stimulus
// against a step-index reference model. Honours XPT_OVERRUN_TRAP_EN.
module tb_xpt_step_sequencer;

   logic       clk = 1'b0;
   logic       rst_n, step_en, wait_n, set_xotr;
   logic       PR_Reset_XPT, P2_Reset_XOTR, P2_Set_CM1, m1_ack;
   logic [4:0] XPT, notXPT;
   logic       xotr_enable, CM1, xpt_error;

   int n_chk  = 0;
   int n_fail = 0;

`ifdef XPT_OVERRUN_TRAP_EN
   localparam bit Trap = 1'b1;
`else
   localparam bit Trap = 1'b0;
`endif

   always #5 clk = ~clk;

   xpt_step_sequencer dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .step_en       (step_en),
      .wait_n        (wait_n),
      .set_xotr      (set_xotr),
      .PR_Reset_XPT  (PR_Reset_XPT),
      .P2_Reset_XOTR (P2_Reset_XOTR),
      .P2_Set_CM1    (P2_Set_CM1),
      .m1_ack        (m1_ack),
      .XPT           (XPT),
      .notXPT        (notXPT),
      .xotr_enable   (xotr_enable),
      .CM1           (CM1),
      .xpt_error     (xpt_error)
   );

   typedef struct {
      logic [7:0] in;   // rst_n step_en wait_n set_xotr pr p2rx p2cm1 m1_ack
      logic [4:0] xpt;
      logic       xotr;
      logic       cm1;
      logic       err;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic [7:0] in, input logic [4:0] x, input logic xo,
                      input logic c, input logic e);
      vec_t v;
      v.in = in; v.xpt = x; v.xotr = xo; v.cm1 = c; v.err = e;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic [7:0] in);
      {rst_n, step_en, wait_n, set_xotr, PR_Reset_XPT, P2_Reset_XOTR, P2_Set_CM1, m1_ack} = in;
   endtask

   task automatic check_all(input string tag, input logic [4:0] x, input logic xo,
                            input logic c, input logic e);
      chk({tag, " XPT"},         XPT,               x);
      chk({tag, " notXPT"},      notXPT,            ~x);
      chk({tag, " xotr_enable"}, {4'b0, xotr_enable}, {4'b0, xo});
      chk({tag, " CM1"},         {4'b0, CM1},         {4'b0, c});
      chk({tag, " xpt_error"},   {4'b0, xpt_error},   {4'b0, e});
   endtask

   // Reference model state: step index 0..4 rather than a one-hot vector.
   int   m_idx;
   logic m_xotr, m_cm1, m_err;

   task automatic model_step(input logic [7:0] in);
      logic r, se, wn, sx, pr, rx, sc, ak;
      {r, se, wn, sx, pr, rx, sc, ak} = in;
      if (!r) begin
         m_idx = 0; m_xotr = 0; m_cm1 = 0; m_err = 0;
      end else begin
         if (pr) m_idx = 0;
         else if (se && wn) begin
            if (m_idx == 4) begin
               if (Trap) m_err = 1'b1;
               else      m_idx = 0;
            end else m_idx = m_idx + 1;
         end
         if (rx)      m_xotr = 1'b0;
         else if (sx) m_xotr = 1'b1;
         if (sc)      m_cm1 = 1'b1;
         else if (ak) m_cm1 = 1'b0;
      end
   endtask

   initial begin
      logic [4:0] wrap_x, after_x;
      logic [7:0] in;
      string      tag;
      wrap_x  = Trap ? 5'b10000 : 5'b00001;
      after_x = Trap ? 5'b10000 : 5'b00010;

      // Bits: rst step wait set pr p2rx p2cm1 ack
      add(8'b0000_0000, 5'b00001, 0, 0, 0); //  0 reset
      add(8'b1110_0000, 5'b00010, 0, 0, 0); //  1 advance
      add(8'b1111_0000, 5'b00100, 1, 0, 0); //  2 advance + set_xotr
      add(8'b1100_0000, 5'b00100, 1, 0, 0); //  3 wait holds
      add(8'b1100_0000, 5'b00100, 1, 0, 0); //  4
      add(8'b1100_0000, 5'b00100, 1, 0, 0); //  5
      add(8'b1100_1000, 5'b00001, 1, 0, 0); //  6 PR reset under wait
      add(8'b1110_0000, 5'b00010, 1, 0, 0); //  7
      add(8'b1110_0000, 5'b00100, 1, 0, 0); //  8
      add(8'b1110_0000, 5'b01000, 1, 0, 0); //  9
      add(8'b1110_1110, 5'b00001, 0, 1, 0); // 10 NEG final step
      add(8'b1110_0001, 5'b00010, 0, 0, 0); // 11 m1_ack clears CM1
      add(8'b1001_0100, 5'b00010, 0, 0, 0); // 12 set+clear XOTR -> 0
      add(8'b1000_0011, 5'b00010, 0, 1, 0); // 13 set+ack CM1 -> 1
      add(8'b1111_0000, 5'b00100, 1, 1, 0); // 14
      add(8'b1110_0000, 5'b01000, 1, 1, 0); // 15 XPT=01000 xotr=1 CM1=1
      add(8'b0111_1111, 5'b00001, 0, 0, 0); // 16 reset overrides all
      add(8'b1110_0000, 5'b00010, 0, 0, 0); // 17
      add(8'b1110_0000, 5'b00100, 0, 0, 0); // 18
      add(8'b1110_0000, 5'b01000, 0, 0, 0); // 19
      add(8'b1110_0000, 5'b10000, 0, 0, 0); // 20
      add(8'b1110_0000, wrap_x,   0, 0, Trap); // 21 advance at last step
      add(8'b1110_0000, after_x,  0, 0, Trap); // 22 error sticky under trap
      add(8'b1000_0000, after_x,  0, 0, Trap); // 23 hold
      add(8'b0000_0000, 5'b00001, 0, 0, 0);    // 24 reset clears error

      drive(8'b0000_0000);
      @(posedge clk); #1;
      foreach (vecs[i]) begin
         drive(vecs[i].in);
         @(posedge clk); #1;
         tag = $sformatf("vec%0d", i);
         check_all(tag, vecs[i].xpt, vecs[i].xotr, vecs[i].cm1, vecs[i].err);
      end

      // Random run against the model, starting from reset.
      model_step(8'b0000_0000);
      drive(8'b0000_0000);
      @(posedge clk); #1;
      for (int c = 0; c < 3000; c++) begin
         in[7] = ($urandom_range(0, 99) != 0);
         in[6] = ($urandom_range(0, 3) != 0);
         in[5] = ($urandom_range(0, 4) != 0);
         in[4] = ($urandom_range(0, 7) == 0);
         in[3] = ($urandom_range(0, 9) == 0);
         in[2] = ($urandom_range(0, 7) == 0);
         in[1] = ($urandom_range(0, 7) == 0);
         in[0] = ($urandom_range(0, 5) == 0);
         drive(in);
         model_step(in);
         @(posedge clk); #1;
         tag = $sformatf("rnd%0d", c);
         check_all(tag, 5'(1 << m_idx), m_xotr, m_cm1, m_err);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
